// File: rtl/hamming_frame_tx_pkg.sv
// Shared Hamming(7,4) definitions for the transmit framer and the syndrome receiver.
// The encode function is the single source of the parity equations.
package hamming_pkg;

  localparam int unsigned DATA_BLK = 4;
  localparam int unsigned CODE_BLK = 7;
  localparam int unsigned PAR_BLK  = 3;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_t;

  function automatic logic [CODE_BLK-1:0] hamming74_encode(input logic [DATA_BLK-1:0] d);
    logic [PAR_BLK-1:0] p;
    p[0] = d[0] ^ d[2] ^ d[3];
    p[1] = d[0] ^ d[1] ^ d[3];
    p[2] = d[0] ^ d[1] ^ d[2];
    return {p, d};
  endfunction

endpackage

// File: rtl/hamming_frame_tx_if.sv
// Word-in / bit-stream-out handshake bundle of the Hamming frame transmitter.
// The master modport is the transmitter side; slave is the environment driving it.
interface hamming_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             inj_en;
  logic [7:0]       inj_pos;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_bit;
  logic             tx_sof;
  logic             tx_eof;

  modport master (
    input  in_valid, in_data, inj_en, inj_pos, tx_ready,
    output in_ready, tx_valid, tx_bit, tx_sof, tx_eof
  );

  modport slave (
    output in_valid, in_data, inj_en, inj_pos, tx_ready,
    input  in_ready, tx_valid, tx_bit, tx_sof, tx_eof
  );
endinterface

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) block encoder: cw = {p2,p1,p0,d3,d2,d1,d0}.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DATA_BLK-1:0] d_i,
  output logic [CODE_BLK-1:0] cw_o
);

  assign cw_o = hamming74_encode(d_i);

endmodule

// File: rtl/hamming_frame_tx.sv
// Hamming(7,4) frame transmitter: encodes a WIDTH-bit word and serialises the codeword
// LSB-first over a valid/ready bit link, with optional single-bit error injection.
module hamming_frame_tx
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  hamming_frame_tx_if.master  bus,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_count
);

  localparam int unsigned BLOCKS  = WIDTH / DATA_BLK;
  localparam int unsigned CW_BITS = BLOCKS * CODE_BLK;
  localparam int unsigned IDX_W   = $clog2(CW_BITS);

  state_t             state_q, state_d;
  logic [CW_BITS-1:0] cw_q, cw_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_en_q, rdy_en_d;
  logic [CW_BITS-1:0] enc_cw;
  logic [CW_BITS-1:0] inj_mask;
  logic               accept;
  logic               last_bit;

  for (genvar i = 0; i < BLOCKS; i++) begin : g_enc
    hamming74_enc u_enc (
      .d_i  (bus.in_data[DATA_BLK*i +: DATA_BLK]),
      .cw_o (enc_cw[CODE_BLK*i +: CODE_BLK])
    );
  end

  // Out-of-range positions match no bit, so they inject nothing.
  always_comb begin
    inj_mask = '0;
    for (int unsigned b = 0; b < CW_BITS; b++) begin
      inj_mask[b] = bus.inj_en && ({24'd0, bus.inj_pos} == b);
    end
  end

  // in_ready stays low until the first clock edge after reset releases.
  assign bus.in_ready = (state_q == IDLE) && rdy_en_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_bit     = (idx_q == IDX_W'(CW_BITS - 1));

  always_comb begin
    state_d  = state_q;
    cw_d     = cw_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rdy_en_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cw_d    = enc_cw ^ inj_mask;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          if (last_bit) begin
            idx_d   = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == SEND);
    bus.tx_valid = busy;
    bus.tx_bit   = busy && cw_q[idx_q];
    bus.tx_sof   = busy && (idx_q == '0);
    bus.tx_eof   = busy && last_bit;
    frame_count  = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cw_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cw_q     <= cw_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_hamming_frame_tx.sv
// Directed bench for hamming_frame_tx (WIDTH=8, CNT_W=4) with hand-computed codewords.
module tb_hamming_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [3:0] frame_count;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  hamming_frame_tx_if #(.WIDTH(8)) bus ();

  hamming_frame_tx #(
    .WIDTH (8),
    .CNT_W (4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic ie, input logic [7:0] ip);
    int g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    chk("tx_valid_idle", 32'(bus.tx_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.inj_en   = ie;
    bus.inj_pos  = ip;
    @(negedge clk);
    // Garbage after accept must not reach the frame in flight.
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hFF;
    bus.inj_en   = 1'b1;
    bus.inj_pos  = 8'd0;
    chk("tx_valid_lat1", 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic recv_frame(input bit rnd, input int stop_at, output logic [13:0] cw);
    int   idx = 0;
    int   guard = 0;
    logic held = 1'b0;
    logic pb = 1'b0;
    cw = '0;
    while (idx < 14 && idx != stop_at && guard < 400) begin
      chk("tx_valid_hold", 32'(bus.tx_valid), 32'd1);
      chk("in_ready_send", 32'(bus.in_ready), 32'd0);
      chk("busy_send", 32'(busy), 32'd1);
      chk("sof_flag", 32'(bus.tx_sof), 32'(idx == 0));
      chk("eof_flag", 32'(bus.tx_eof), 32'(idx == 13));
      if (held) chk("bit_stable", 32'(bus.tx_bit), 32'(pb));
      bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.tx_ready) begin
        cw[idx] = bus.tx_bit;
        idx++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        pb   = bus.tx_bit;
      end
      @(negedge clk);
      guard++;
    end
    bus.tx_ready = 1'b0;
    if (guard >= 400) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [13:0] cw;
    int          t_prev;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.inj_en   = 1'b0;
    bus.inj_pos  = '0;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk("idle_tx_sof", 32'(bus.tx_sof), 32'd0);

    send_word(8'h00, 1'b0, 8'd0);
    recv_frame(1'b0, -1, cw);
    chk("cw_00", 32'(cw), 32'h0000);
    chk("count_1", 32'(frame_count), 32'd1);

    send_word(8'h0B, 1'b0, 8'd0);
    recv_frame(1'b0, -1, cw);
    chk("cw_0b", 32'(cw), 32'h002B);
    chk("count_2", 32'(frame_count), 32'd2);

    send_word(8'hF0, 1'b1, 8'd3);
    recv_frame(1'b0, -1, cw);
    chk("cw_f0_inj3", 32'(cw), 32'h3F88);

    send_word(8'hF0, 1'b1, 8'd14);
    recv_frame(1'b0, -1, cw);
    chk("cw_f0_inj_oob", 32'(cw), 32'h3F80);

    send_word(8'h5A, 1'b0, 8'd0);
    recv_frame(1'b1, -1, cw);
    chk("cw_5a_stall", 32'(cw), 32'h12DA);
    chk("count_5", 32'(frame_count), 32'd5);

    // Abort a frame with bit 6 on the wire.
    send_word(8'h5A, 1'b0, 8'd0);
    recv_frame(1'b0, 6, cw);
    chk("cw_5a_partial", 32'(cw[5:0]), 32'h1A);
    do_reset();
    send_word(8'h0B, 1'b0, 8'd0);
    recv_frame(1'b0, -1, cw);
    chk("cw_0b_after_abort", 32'(cw), 32'h002B);
    chk("count_after_abort", 32'(frame_count), 32'd1);

    do_reset();
    t_prev = 0;
    for (int f = 0; f < 17; f++) begin
      if (f > 0) chk("frame_period", 32'(cyc - t_prev), 32'd15);
      t_prev = cyc;
      send_word(8'h0B, 1'b0, 8'd0);
      recv_frame(1'b0, -1, cw);
      chk("cw_b2b", 32'(cw), 32'h002B);
      chk("count_b2b", 32'(frame_count), 32'((f + 1) % 16));
    end
    chk("count_wrap", 32'(frame_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
